morse_decoder: RTL and testbench

- Downstream consumer of the button front-end. Takes its `morse_signal` element code and `letter_spacing` flag.
- Collects dot/dash elements into a per-letter buffer. On each letter gap, translates the buffer to 7-bit ASCII: A–Z and 0–9.
- Result goes out as a one-cycle `char_valid` strobe plus a held character register, for the display/UART stage.

---
 rtl/morse_decoder.sv | 137 +++++++++++++
 tb/tb_morse_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - collects dot/dash elements and decodes each letter to ASCII A-Z, 0-9
module morse_decoder #(
    parameter int          MAX_ELEMS = 5,
    parameter logic [7:0]  ERR_CHAR  = 8'h3F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] morse_signal,
    input  logic       letter_spacing,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       char_err,
    output logic [2:0] elem_count,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             ms_q, ms_d;
    logic                   ls_q, ls_d;
    logic [MAX_ELEMS-1:0]   elem_bits_q, elem_bits_d;
    logic [2:0]             count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             char_out_q, char_out_d;
    logic                   char_valid_q, char_valid_d;
    logic                   char_err_q, char_err_d;

    logic                   elem_event, gap_edge, do_emit;
    logic [MAX_ELEMS-1:0]   bits_n;
    logic [2:0]             count_n;
    logic                   ovf_n;
    logic [7:0]             lut;

    // Returns 8'h00 when the (length, pattern) pair is not a known symbol.
    function automatic logic [7:0] lookup(input logic [2:0] n, input logic [4:0] b);
        case ({n, b})
            {3'd2, 5'b00001}: lookup = 8'h41;  {3'd4, 5'b01000}: lookup = 8'h42;
            {3'd4, 5'b01010}: lookup = 8'h43;  {3'd3, 5'b00100}: lookup = 8'h44;
            {3'd1, 5'b00000}: lookup = 8'h45;  {3'd4, 5'b00010}: lookup = 8'h46;
            {3'd3, 5'b00110}: lookup = 8'h47;  {3'd4, 5'b00000}: lookup = 8'h48;
            {3'd2, 5'b00000}: lookup = 8'h49;  {3'd4, 5'b00111}: lookup = 8'h4A;
            {3'd3, 5'b00101}: lookup = 8'h4B;  {3'd4, 5'b00100}: lookup = 8'h4C;
            {3'd2, 5'b00011}: lookup = 8'h4D;  {3'd2, 5'b00010}: lookup = 8'h4E;
            {3'd3, 5'b00111}: lookup = 8'h4F;  {3'd4, 5'b00110}: lookup = 8'h50;
            {3'd4, 5'b01101}: lookup = 8'h51;  {3'd3, 5'b00010}: lookup = 8'h52;
            {3'd3, 5'b00000}: lookup = 8'h53;  {3'd1, 5'b00001}: lookup = 8'h54;
            {3'd3, 5'b00001}: lookup = 8'h55;  {3'd4, 5'b00001}: lookup = 8'h56;
            {3'd3, 5'b00011}: lookup = 8'h57;  {3'd4, 5'b01001}: lookup = 8'h58;
            {3'd4, 5'b01011}: lookup = 8'h59;  {3'd4, 5'b01100}: lookup = 8'h5A;
            {3'd5, 5'b11111}: lookup = 8'h30;  {3'd5, 5'b01111}: lookup = 8'h31;
            {3'd5, 5'b00111}: lookup = 8'h32;  {3'd5, 5'b00011}: lookup = 8'h33;
            {3'd5, 5'b00001}: lookup = 8'h34;  {3'd5, 5'b00000}: lookup = 8'h35;
            {3'd5, 5'b10000}: lookup = 8'h36;  {3'd5, 5'b11000}: lookup = 8'h37;
            {3'd5, 5'b11100}: lookup = 8'h38;  {3'd5, 5'b11110}: lookup = 8'h39;
            default:          lookup = 8'h00;
        endcase
    endfunction

    assign elem_event = (morse_signal == 2'b10 || morse_signal == 2'b01) && (morse_signal != ms_q);
    assign gap_edge   = letter_spacing && !ls_q;

    always_comb begin
        ms_d         = morse_signal;
        ls_d         = letter_spacing;
        state_d      = state_q;
        char_out_d   = char_out_q;
        char_err_d   = char_err_q;
        char_valid_d = 1'b0;

        // The element of this cycle is appended before any decode, so it is part of the letter.
        bits_n  = elem_bits_q;
        count_n = count_q;
        ovf_n   = ovf_q;
        if (elem_event) begin
            if (count_q == 3'(MAX_ELEMS)) begin
                ovf_n = 1'b1;
            end else begin
                bits_n  = {elem_bits_q[MAX_ELEMS-2:0], (morse_signal == 2'b01)};
                count_n = count_q + 3'd1;
            end
        end
        lut = lookup(count_n, 5'(bits_n));

        case (state_q)
            IDLE:    do_emit = gap_edge && elem_event;
            COLLECT: do_emit = gap_edge;
            default: do_emit = gap_edge && elem_event;
        endcase

        if (do_emit) begin
            char_valid_d = 1'b1;
            char_err_d   = ovf_n || (lut == 8'h00);
            char_out_d   = char_err_d ? ERR_CHAR : lut;
            elem_bits_d  = '0;
            count_d      = 3'd0;
            ovf_d        = 1'b0;
            state_d      = EMIT;
        end else begin
            elem_bits_d  = bits_n;
            count_d      = count_n;
            ovf_d        = ovf_n;
            state_d      = (count_n != 3'd0) ? COLLECT : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ms_q         <= 2'b00;
            ls_q         <= 1'b0;
            elem_bits_q  <= '0;
            count_q      <= 3'd0;
            ovf_q        <= 1'b0;
            char_out_q   <= 8'h00;
            char_valid_q <= 1'b0;
            char_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ms_q         <= ms_d;
            ls_q         <= ls_d;
            elem_bits_q  <= elem_bits_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            char_err_q   <= char_err_d;
        end
    end

    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign char_err   = char_err_q;
    assign elem_count = count_q;
    assign busy       = (count_q != 3'd0);

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - randomized self-checking bench for morse_decoder against a string-table model
module tb_morse_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] morse_signal;
    logic       letter_spacing;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_err;
    logic [2:0] elem_count;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] last_char;

    string      codes [36];
    logic [7:0] chars [36];

    always #5 clk = ~clk;

    morse_decoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .morse_signal   (morse_signal),
        .letter_spacing (letter_spacing),
        .char_out       (char_out),
        .char_valid     (char_valid),
        .char_err       (char_err),
        .elem_count     (elem_count),
        .busy           (busy)
    );

    function automatic logic [7:0] model_decode(string s);
        if (s.len() > 5) return 8'h3F;
        for (int i = 0; i < 36; i++)
            if (codes[i] == s) return chars[i];
        return 8'h3F;
    endfunction

    function automatic int model_count(string s);
        return (s.len() > 5) ? 5 : s.len();
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // hold == 0 picks random element/space lengths; random 2'b11 glitches sit only between 00s
    task automatic send_code(input string s, input int hold);
        for (int i = 0; i < s.len(); i++) begin
            morse_signal = (s[i] == "-") ? 2'b01 : 2'b10;
            tick(hold != 0 ? hold : int'($urandom_range(1, 4)));
            morse_signal = 2'b00;
            tick(hold != 0 ? hold : int'($urandom_range(1, 3)));
            if (hold == 0 && $urandom_range(0, 3) == 0) begin
                morse_signal = 2'b11;
                tick(int'($urandom_range(1, 2)));
                morse_signal = 2'b00;
                tick(1);
            end
        end
    endtask

    task automatic gap_observe(output logic v1, output logic [7:0] c, output logic e,
                               output logic [2:0] cnt, output logic v2);
        letter_spacing = 1'b1;
        tick(1);
        v1  = char_valid;
        c   = char_out;
        e   = char_err;
        cnt = elem_count;
        tick(1);
        v2  = char_valid;
        letter_spacing = 1'b0;
        tick(2);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; morse_signal = 2'b00; letter_spacing = 1'b0;
        tick(2);
        n_checks++; if (char_out !== 8'h00) $display("FAIL reset_char_out got %h exp 00", char_out); else n_pass++;
        n_checks++; if (char_valid !== 1'b0) $display("FAIL reset_char_valid got %b exp 0", char_valid); else n_pass++;
        n_checks++; if (char_err !== 1'b0) $display("FAIL reset_char_err got %b exp 0", char_err); else n_pass++;
        n_checks++; if (elem_count !== 3'd0) $display("FAIL reset_elem_count got %0d exp 0", elem_count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_letter_a;
        logic v1, v2, e; logic [7:0] c; logic [2:0] cnt;
        send_code(".-", 20);
        n_checks++; if (elem_count !== 3'd2 || busy !== 1'b1) $display("FAIL a_count got %0d/%b exp 2/1", elem_count, busy); else n_pass++;
        gap_observe(v1, c, e, cnt, v2);
        n_checks++; if (v1 !== 1'b1 || v2 !== 1'b0) $display("FAIL a_strobe got %b%b exp 10", v1, v2); else n_pass++;
        n_checks++; if (c !== 8'h41 || e !== 1'b0) $display("FAIL a_char got %h/%b exp 41/0", c, e); else n_pass++;
        n_checks++; if (cnt !== 3'd0) $display("FAIL a_cleared got %0d exp 0", cnt); else n_pass++;
        last_char = 8'h41;
    endtask

    task automatic test_random_letters;
        logic v1, v2, e; logic [7:0] c, exp_c; logic [2:0] cnt;
        string s;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                s = codes[$urandom_range(0, 35)];
            end else begin
                s = "";
                for (int k = 0; k < int'($urandom_range(1, 7)); k++)
                    s = {s, ($urandom_range(0, 1) != 0) ? "-" : "."};
            end
            exp_c = model_decode(s);
            send_code(s, 0);
            n_checks++;
            if (elem_count !== 3'(model_count(s))) $display("FAIL rand_count[%s] got %0d exp %0d", s, elem_count, model_count(s));
            else n_pass++;
            gap_observe(v1, c, e, cnt, v2);
            n_checks++;
            if (v1 !== 1'b1 || v2 !== 1'b0 || c !== exp_c || e !== (exp_c == 8'h3F) || cnt !== 3'd0)
                $display("FAIL rand_decode[%s] got v=%b%b c=%h e=%b n=%0d exp v=10 c=%h e=%b n=0",
                         s, v1, v2, c, e, cnt, exp_c, (exp_c == 8'h3F));
            else n_pass++;
            last_char = exp_c;
        end
    endtask

    task automatic test_digits;
        logic v1, v2, e; logic [7:0] c; logic [2:0] cnt;
        send_code("-----", 0);
        gap_observe(v1, c, e, cnt, v2);
        n_checks++; if (v1 !== 1'b1 || c !== 8'h30 || e !== 1'b0) $display("FAIL digit0 got %b/%h/%b exp 1/30/0", v1, c, e); else n_pass++;
        send_code(".....", 0);
        gap_observe(v1, c, e, cnt, v2);
        n_checks++; if (v1 !== 1'b1 || c !== 8'h35 || e !== 1'b0) $display("FAIL digit5 got %b/%h/%b exp 1/35/0", v1, c, e); else n_pass++;
        last_char = 8'h35;
    endtask

    task automatic test_overflow;
        logic v1, v2, e; logic [7:0] c; logic [2:0] cnt;
        send_code("......", 3);
        n_checks++; if (elem_count !== 3'd5) $display("FAIL ovf_count got %0d exp 5", elem_count); else n_pass++;
        gap_observe(v1, c, e, cnt, v2);
        n_checks++; if (v1 !== 1'b1 || c !== 8'h3F || e !== 1'b1) $display("FAIL ovf_decode got %b/%h/%b exp 1/3f/1", v1, c, e); else n_pass++;
        last_char = 8'h3F;
    endtask

    task automatic test_invalid;
        logic v1, v2, e; logic [7:0] c; logic [2:0] cnt;
        send_code("..", 2);
        morse_signal = 2'b11;
        tick(4);
        n_checks++; if (elem_count !== 3'd2) $display("FAIL illegal_ignored got %0d exp 2", elem_count); else n_pass++;
        morse_signal = 2'b00;
        tick(2);
        send_code("--", 2);
        gap_observe(v1, c, e, cnt, v2);
        n_checks++; if (v1 !== 1'b1 || c !== 8'h3F || e !== 1'b1) $display("FAIL invalid_decode got %b/%h/%b exp 1/3f/1", v1, c, e); else n_pass++;
        last_char = 8'h3F;
    endtask

    task automatic test_empty_gap;
        int strobes = 0;
        letter_spacing = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (char_valid === 1'b1) strobes++;
        end
        letter_spacing = 1'b0;
        tick(2);
        n_checks++; if (strobes != 0) $display("FAIL empty_gap_strobes got %0d exp 0", strobes); else n_pass++;
        n_checks++; if (char_out !== last_char) $display("FAIL empty_gap_hold got %h exp %h", char_out, last_char); else n_pass++;
    endtask

    task automatic test_held_gap;
        int strobes = 0;
        send_code("-.-", 0);
        letter_spacing = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (char_valid === 1'b1) strobes++;
        end
        letter_spacing = 1'b0;
        tick(2);
        n_checks++; if (strobes != 1) $display("FAIL held_gap_strobes got %0d exp 1", strobes); else n_pass++;
        n_checks++; if (char_out !== 8'h4B) $display("FAIL held_gap_char got %h exp 4b", char_out); else n_pass++;
        last_char = 8'h4B;
    endtask

    task automatic test_back_to_back;
        logic v1, v2, e; logic [7:0] c; logic [2:0] cnt;
        send_code(".-", 2);
        morse_signal = 2'b01;
        letter_spacing = 1'b1;
        tick(1);
        n_checks++;
        if (char_valid !== 1'b1 || char_out !== model_decode(".--") || elem_count !== 3'd0)
            $display("FAIL simultaneous got %b/%h/%0d exp 1/%h/0", char_valid, char_out, elem_count, model_decode(".--"));
        else n_pass++;
        morse_signal = 2'b00; letter_spacing = 1'b0;
        tick(2);
        send_code("...", 2);
        letter_spacing = 1'b1;
        tick(1);
        n_checks++; if (char_valid !== 1'b1 || char_out !== 8'h53) $display("FAIL emit_s got %b/%h exp 1/53", char_valid, char_out); else n_pass++;
        morse_signal = 2'b10;
        tick(1);
        n_checks++;
        if (elem_count !== 3'd1 || busy !== 1'b1 || char_valid !== 1'b0)
            $display("FAIL elem_in_emit got %0d/%b/%b exp 1/1/0", elem_count, busy, char_valid);
        else n_pass++;
        morse_signal = 2'b00; letter_spacing = 1'b0;
        tick(2);
        gap_observe(v1, c, e, cnt, v2);
        n_checks++; if (v1 !== 1'b1 || c !== 8'h45 || e !== 1'b0) $display("FAIL after_emit_e got %b/%h/%b exp 1/45/0", v1, c, e); else n_pass++;
        last_char = 8'h45;
    endtask

    task automatic test_reset_mid_letter;
        logic v1, v2, e; logic [7:0] c; logic [2:0] cnt;
        send_code("--.", 2);
        n_checks++; if (elem_count !== 3'd3) $display("FAIL mid_count got %0d exp 3", elem_count); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (char_out !== 8'h00 || char_valid !== 1'b0 || char_err !== 1'b0 || elem_count !== 3'd0 || busy !== 1'b0)
            $display("FAIL async_reset got c=%h v=%b e=%b n=%0d b=%b exp 00/0/0/0/0", char_out, char_valid, char_err, elem_count, busy);
        else n_pass++;
        #2 rst_n = 1'b1;
        tick(2);
        gap_observe(v1, c, e, cnt, v2);
        n_checks++; if (v1 !== 1'b0 || v2 !== 1'b0) $display("FAIL post_reset_gap got %b%b exp 00", v1, v2); else n_pass++;
        send_code(".", 0);
        gap_observe(v1, c, e, cnt, v2);
        n_checks++; if (v1 !== 1'b1 || c !== 8'h45 || e !== 1'b0) $display("FAIL post_reset_e got %b/%h/%b exp 1/45/0", v1, c, e); else n_pass++;
    endtask

    initial begin
        codes = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                  "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                  "..-", "...-", ".--", "-..-", "-.--", "--..",
                  "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};
        for (int i = 0; i < 36; i++)
            chars[i] = (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
        last_char = 8'h00;

        test_reset;
        test_letter_a;
        test_digits;
        test_overflow;
        test_invalid;
        test_empty_gap;
        test_held_gap;
        test_back_to_back;
        test_random_letters;
        test_reset_mid_letter;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
